// File: rtl/load_store_unit.sv
// Load/store unit: turns one core load/store request into one or two word-aligned
// memory accesses with byte strobes, and returns extended load data.
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              store_q, store_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] hi_q, hi_d;

  // Stores only accept the three sized variants; loads add the unsigned pair.
  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = !store;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic [1:0]          off_s;
  logic [3:0]          mask_s;
  logic [3:0]          size_s;
  logic [7:0]          strb8_s;
  logic [2*DATA_W-1:0] wdata64_s;
  logic                split_s;
  logic [ADDR_W-1:0]   word0_s;
  logic [ADDR_W-1:0]   word1_s;
  logic [DATA_W-1:0]   rd_sh_s;
  logic [DATA_W-1:0]   load_ext_s;

  // Size/offset decode of the captured request into the 8-byte window.
  always_comb begin
    off_s = addr_q[1:0];
    case (funct3_q[1:0])
      2'b00:   begin mask_s = 4'b0001; size_s = 4'd1; end
      2'b01:   begin mask_s = 4'b0011; size_s = 4'd2; end
      default: begin mask_s = 4'b1111; size_s = 4'd4; end
    endcase
    strb8_s   = {4'b0000, mask_s} << off_s;
    wdata64_s = {{DATA_W{1'b0}}, wdata_q} << {off_s, 3'b000};
    split_s   = ({2'b00, off_s} + size_s) > 4'd4;
    word0_s   = {addr_q[ADDR_W-1:2], 2'b00};
    word1_s   = word0_s + ADDR_W'(4);
    rd_sh_s   = DATA_W'({hi_q, lo_q} >> {off_s, 3'b000});
    case (funct3_q)
      3'b000:  load_ext_s = {{(DATA_W-8){rd_sh_s[7]}}, rd_sh_s[7:0]};
      3'b001:  load_ext_s = {{(DATA_W-16){rd_sh_s[15]}}, rd_sh_s[15:0]};
      3'b010:  load_ext_s = rd_sh_s;
      3'b100:  load_ext_s = {{(DATA_W-8){1'b0}}, rd_sh_s[7:0]};
      3'b101:  load_ext_s = {{(DATA_W-16){1'b0}}, rd_sh_s[15:0]};
      default: load_ext_s = {DATA_W{1'b0}};
    endcase
  end

  // Next-state and output decode; every output idles at zero outside its state.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    funct3_d   = funct3_q;
    store_d    = store_q;
    err_d      = err_q;
    wdata_d    = wdata_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = {DATA_W{1'b0}};
    resp_err   = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = {ADDR_W{1'b0}};
    mem_wstrb  = 4'b0000;
    mem_wdata  = {DATA_W{1'b0}};
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d   = req_addr;
          funct3_d = req_funct3;
          store_d  = req_store;
          wdata_d  = req_wdata;
          err_d    = !f3_legal(req_store, req_funct3);
          lo_d     = {DATA_W{1'b0}};
          hi_d     = {DATA_W{1'b0}};
          state_d  = f3_legal(req_store, req_funct3) ? ST_ACC0 : ST_RESP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACC0: begin
        mem_en    = 1'b1;
        mem_we    = store_q;
        mem_addr  = word0_s;
        mem_wstrb = store_q ? strb8_s[3:0] : 4'b0000;
        mem_wdata = wdata64_s[DATA_W-1:0];
        if (!store_q) begin
          lo_d = mem_rdata;
        end else begin
          lo_d = lo_q;
        end
        state_d = split_s ? ST_ACC1 : ST_RESP;
      end
      ST_ACC1: begin
        mem_en    = 1'b1;
        mem_we    = store_q;
        mem_addr  = word1_s;
        mem_wstrb = store_q ? strb8_s[7:4] : 4'b0000;
        mem_wdata = wdata64_s[2*DATA_W-1:DATA_W];
        if (!store_q) begin
          hi_d = mem_rdata;
        end else begin
          hi_d = hi_q;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (err_q || store_q) begin
          resp_rdata = {DATA_W{1'b0}};
        end else begin
          resp_rdata = load_ext_s;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and request/data buffers; reset drops any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= {ADDR_W{1'b0}};
      funct3_q <= 3'b000;
      store_q  <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= {DATA_W{1'b0}};
      lo_q     <= {DATA_W{1'b0}};
      hi_q     <= {DATA_W{1'b0}};
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      store_q  <= store_d;
      err_q    <= err_d;
      wdata_q  <= wdata_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-addressed reference memory predicts
// each response; a monitor pops predictions whenever the DUT responds.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Word memory seen by the DUT: regions 0x000-0x03F, 0x100-0x13F, 0xFFFFFFC0-0xFFFFFFFF.
  logic [31:0] dmem [64];
  logic [5:0]  m_idx;
  assign m_idx     = {mem_addr[31], mem_addr[8], mem_addr[5:2]};
  assign mem_rdata = dmem[m_idx];

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wstrb[b]) dmem[m_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Reference memory: plain bytes, same three regions.
  logic [7:0] rmem [256];
  function automatic logic [7:0] ridx(input logic [31:0] a);
    return {a[31], a[8], a[5:0]};
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic legal(input logic st, input logic [2:0] f3);
    if (st) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    else    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                   (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < size_of(f3); i++) v[8*i +: 8] = rmem[ridx(a + 32'(i))];
    if (f3 == 3'b000 && v[7])  v[31:8]  = 24'hFFFFFF;
    if (f3 == 3'b001 && v[15]) v[31:16] = 16'hFFFF;
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < size_of(f3); i++) rmem[ridx(a + 32'(i))] = d[8*i +: 8];
  endtask

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          hs;
    int          lat;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } acc_t;

  exp_t exp_q[$];
  acc_t acc_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic ok, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, expv, $time);
  endtask

  // Monitor: interface invariants, access log, and scoreboard comparison.
  always @(negedge clk) begin
    if (rst_n) begin
      check("idle_outputs_zero",
            (mem_en || (!mem_we && mem_addr == 32'h0 && mem_wstrb == 4'h0 && mem_wdata == 32'h0)) &&
            (resp_valid || (resp_rdata == 32'h0 && !resp_err)) &&
            !(req_ready && resp_valid) &&
            (!mem_en || mem_addr[1:0] == 2'b00) && (mem_we || mem_wstrb == 4'h0),
            {mem_en, resp_valid, req_ready}, 32'h0);
      if (mem_en) acc_q.push_back('{mem_we, mem_addr, mem_wstrb, mem_wdata});
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 1'b0, resp_rdata, 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("resp_rdata", resp_rdata == e.rdata, resp_rdata, e.rdata);
          check("resp_err", resp_err == e.err, 32'(resp_err), 32'(e.err));
          check("resp_latency", (cyc - e.hs) == e.lat, 32'(cyc - e.hs), 32'(e.lat));
        end
      end
    end
  end

  // Issue one request at a negedge, hold junk during the busy cycle, then drop valid.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic use_exp, input logic [31:0] expd,
                       input logic push);
    exp_t e;
    int   sz;
    int   k;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) check("ready_timeout", 1'b0, 32'(req_ready), 32'h1);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    sz         = size_of(f3);
    e.err      = !legal(st, f3);
    e.lat      = e.err ? 1 : ((int'(a[1:0]) + sz > 4) ? 3 : 2);
    e.rdata    = (e.err || st) ? 32'h0 : ref_load(f3, a);
    if (use_exp) e.rdata = expd;
    e.hs       = cyc;
    if (!e.err && st) ref_store(f3, a, wd);
    if (push) exp_q.push_back(e);
    @(negedge clk);
    req_store  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) check("resp_timeout", 1'b0, 32'(exp_q.size()), 32'h0);
    @(negedge clk);
  endtask

  task automatic chk_acc(input int i, input logic we, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] wd, input logic chk_data);
    if (i < acc_q.size()) begin
      check("acc_addr", acc_q[i].addr == a, acc_q[i].addr, a);
      check("acc_we", acc_q[i].we == we, 32'(acc_q[i].we), 32'(we));
      if (chk_data) begin
        check("acc_wstrb", acc_q[i].strb == s, 32'(acc_q[i].strb), 32'(s));
        check("acc_wdata", acc_q[i].wdata == wd, acc_q[i].wdata, wd);
      end
    end else begin
      check("acc_missing", 1'b0, 32'(acc_q.size()), 32'(i + 1));
    end
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] a;
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if (i == 32'h10) w = 32'h8899AABB;
      if (i == 32'h11) w = 32'h11223344;
      dmem[i] <= w;
      for (int b = 0; b < 4; b++) rmem[i*4 + b] = w[8*b +: 8];
    end
    #12;
    check("reset_ready", req_ready == 1'b1, 32'(req_ready), 32'h1);
    check("reset_outputs_zero",
          {resp_valid, resp_err, mem_en, mem_we} == 4'h0 && resp_rdata == 32'h0 &&
          mem_addr == 32'h0 && mem_wstrb == 4'h0 && mem_wdata == 32'h0,
          {resp_valid, resp_err, mem_en, mem_we}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    acc_q.delete(); issue(1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 32'h8899AABB, 1'b1); wait_done();
    check("lw_aligned_nacc", acc_q.size() == 1, 32'(acc_q.size()), 32'h1);
    chk_acc(0, 1'b0, 32'h100, 4'h0, 32'h0, 1'b0);

    acc_q.delete(); issue(1'b0, 3'b010, 32'h102, 32'h0, 1'b1, 32'h33448899, 1'b1); wait_done();
    check("lw_split_nacc", acc_q.size() == 2, 32'(acc_q.size()), 32'h2);
    chk_acc(0, 1'b0, 32'h100, 4'h0, 32'h0, 1'b0);
    chk_acc(1, 1'b0, 32'h104, 4'h0, 32'h0, 1'b0);

    acc_q.delete(); issue(1'b0, 3'b001, 32'h103, 32'h0, 1'b1, 32'h00004488, 1'b1); wait_done();
    check("lh_split_nacc", acc_q.size() == 2, 32'(acc_q.size()), 32'h2);
    issue(1'b0, 3'b101, 32'h103, 32'h0, 1'b1, 32'h00004488, 1'b1); wait_done();
    acc_q.delete(); issue(1'b0, 3'b000, 32'h103, 32'h0, 1'b1, 32'hFFFFFF88, 1'b1); wait_done();
    check("lb_nacc", acc_q.size() == 1, 32'(acc_q.size()), 32'h1);
    issue(1'b0, 3'b100, 32'h103, 32'h0, 1'b1, 32'h00000088, 1'b1); wait_done();

    acc_q.delete(); issue(1'b1, 3'b010, 32'h106, 32'hDEADBEEF, 1'b1, 32'h0, 1'b1); wait_done();
    check("sw_split_nacc", acc_q.size() == 2, 32'(acc_q.size()), 32'h2);
    chk_acc(0, 1'b1, 32'h104, 4'b1100, 32'hBEEF0000, 1'b1);
    chk_acc(1, 1'b1, 32'h108, 4'b0011, 32'h0000DEAD, 1'b1);

    acc_q.delete(); issue(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h0, 1'b1); wait_done();
    chk_acc(0, 1'b0, 32'hFFFFFFFC, 4'h0, 32'h0, 1'b0);
    chk_acc(1, 1'b0, 32'h00000000, 4'h0, 32'h0, 1'b0);

    acc_q.delete(); issue(1'b0, 3'b011, 32'h100, 32'h0, 1'b0, 32'h0, 1'b1); wait_done();
    check("illegal_no_access", acc_q.size() == 0, 32'(acc_q.size()), 32'h0);
    acc_q.delete(); issue(1'b1, 3'b100, 32'h101, 32'h12345678, 1'b0, 32'h0, 1'b1); wait_done();
    check("illegal_store_no_access", acc_q.size() == 0, 32'(acc_q.size()), 32'h0);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 2))
        0:       a = 32'h000 + 32'($urandom_range(0, 59));
        1:       a = 32'h100 + 32'($urandom_range(0, 59));
        default: a = 32'hFFFFFFC0 + 32'($urandom_range(0, 63));
      endcase
      issue(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, 1'b0, 32'h0, 1'b1);
      if ($urandom_range(0, 3) == 0) wait_done();
    end
    wait_done();

    // Reset while the second word of a split load is on the bus.
    issue(1'b0, 3'b010, 32'h102, 32'h0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midreset_ready", req_ready == 1'b1, 32'(req_ready), 32'h1);
    check("midreset_outputs_zero",
          {resp_valid, mem_en, mem_we} == 3'h0 && mem_addr == 32'h0 && mem_wstrb == 4'h0,
          {resp_valid, mem_en, mem_we}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'h0, 1'b1);
    wait_done();

    for (int i = 0; i < 64; i++) begin
      check("final_memory", dmem[i] == {rmem[i*4+3], rmem[i*4+2], rmem[i*4+1], rmem[i*4]},
            dmem[i], {rmem[i*4+3], rmem[i*4+2], rmem[i*4+1], rmem[i*4]});
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
